// File: rtl/demux_pkg.sv
// Shared types and helpers for the 1-to-4 stream demultiplexer.
// Port selects and the round-robin pointer share one 2-bit type.
package demux_pkg;

  localparam int NUM_PORTS = 4;

  typedef logic [1:0] port_sel_t;

  // Wrapping increment: 3 rolls over to 0 through the 2-bit result.
  function automatic port_sel_t next_ptr(input port_sel_t ptr);
    return port_sel_t'(ptr + 2'd1);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding register with a valid/ready handshake.
// free_o lets the top accept into this slot even while it drains in the same cycle.
module demux_slot #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             drain_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             free_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && drain_i) begin
      // Data is left in place after a drain; only the valid flag drops.
      valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign free_o  = !valid_q || drain_i;

endmodule

// File: rtl/demux1to4_stream.sv
// Registered 1-to-4 stream demultiplexer: explicit or round-robin steering into
// four independent holding slots, so back-pressure on one output stalls only its beats.
module demux1to4_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rr_en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  port_sel_t            in_sel,
  input  logic [WIDTH-1:0]     in_data,
  output logic [NUM_PORTS-1:0] out_valid,
  input  logic [NUM_PORTS-1:0] out_ready,
  output logic [WIDTH-1:0]     out0_data,
  output logic [WIDTH-1:0]     out1_data,
  output logic [WIDTH-1:0]     out2_data,
  output logic [WIDTH-1:0]     out3_data,
  output port_sel_t            rr_ptr
);

  port_sel_t            target;
  port_sel_t            rr_ptr_q, rr_ptr_d;
  logic                 accept;
  logic [NUM_PORTS-1:0] load;
  logic [NUM_PORTS-1:0] slot_free;
  logic [WIDTH-1:0]     slot_data [NUM_PORTS];

  // in_ready never looks at in_valid, keeping the handshake loop-free.
  always_comb begin
    target   = rr_en ? rr_ptr_q : in_sel;
    in_ready = slot_free[target];
    accept   = in_valid && in_ready;
    load     = '0;
    load[target] = accept;
    rr_ptr_d = (accept && rr_en) ? next_ptr(rr_ptr_q) : rr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  for (genvar n = 0; n < NUM_PORTS; n++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load[n]),
      .drain_i (out_ready[n]),
      .data_i  (in_data),
      .valid_o (out_valid[n]),
      .data_o  (slot_data[n]),
      .free_o  (slot_free[n])
    );
  end

  assign out0_data = slot_data[0];
  assign out1_data = slot_data[1];
  assign out2_data = slot_data[2];
  assign out3_data = slot_data[3];
  assign rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_demux1to4_stream.sv
// Self-checking bench for demux1to4_stream: a cycle model with per-port
// scoreboard queues checks every handshake, plus directed checks per scenario.
module tb_demux1to4_stream;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rr_en;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_sel;
  logic [W-1:0] in_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [W-1:0] out0_data, out1_data, out2_data, out3_data;
  logic [1:0]   rr_ptr;

  demux1to4_stream #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rr_en     (rr_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0_data (out0_data),
    .out1_data (out1_data),
    .out2_data (out2_data),
    .out3_data (out3_data),
    .rr_ptr    (rr_ptr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state and scoreboard
  logic [W-1:0] od [4];
  logic [W-1:0] sb [4][$];
  logic [3:0]   m_valid = '0;
  logic [W-1:0] m_data [4] = '{default: '0};
  logic [1:0]   m_ptr = '0;
  bit           mon_en = 1'b0;

  assign od[0] = out0_data;
  assign od[1] = out1_data;
  assign od[2] = out2_data;
  assign od[3] = out3_data;

  // Inputs change only just after posedge, so negedge sees the values the next edge will use.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [1:0] t;
      logic       exp_rdy;
      logic [W-1:0] exp_d;
      logic [3:0] nxt_valid;
      check("out_valid", out_valid, m_valid);
      check("rr_ptr", rr_ptr, m_ptr);
      for (int n = 0; n < 4; n++) check($sformatf("out%0d_data", n), od[n], m_data[n]);
      t       = rr_en ? m_ptr : in_sel;
      exp_rdy = !m_valid[t] || out_ready[t];
      check("in_ready", in_ready, exp_rdy);
      if (!rst_n) begin
        m_valid = '0;
        m_ptr   = '0;
        for (int n = 0; n < 4; n++) begin
          m_data[n] = '0;
          sb[n].delete();
        end
      end else begin
        for (int n = 0; n < 4; n++) begin
          if (m_valid[n] && out_ready[n]) begin
            if (sb[n].size() == 0) check($sformatf("sb%0d_unexpected", n), od[n], 32'hDEAD);
            else begin
              exp_d = sb[n].pop_front();
              check($sformatf("drain%0d", n), od[n], exp_d);
            end
          end
        end
        nxt_valid = m_valid & ~out_ready;
        if (in_valid && exp_rdy) begin
          nxt_valid[t] = 1'b1;
          m_data[t]    = in_data;
          sb[t].push_back(in_data);
          if (rr_en) m_ptr = m_ptr + 2'd1;
        end
        m_valid = nxt_valid;
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [1:0] sel);
    bit acc = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = sel;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("send_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    rr_en     = 1'b1;
    in_valid  = 1'b1;
    in_sel    = 2'd2;
    in_data   = 8'hFF;
    out_ready = 4'b0000;
    @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    rr_en    = 1'b0;

    // Explicit steering
    out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), 2'(i));
    repeat (2) @(posedge clk);
    #1;

    // Back-pressure isolation on port 0
    out_ready = 4'b1110;
    send(8'h11, 2'd0);
    fork
      send(8'h22, 2'd0);
      begin
        repeat (2) @(negedge clk);
        check("bp_stall_ready", in_ready, 0);
        check("bp_hold_data", out0_data, 8'h11);
        @(posedge clk);
        #1 out_ready = 4'b1111;
      end
    join
    send(8'h33, 2'd1);
    repeat (2) @(posedge clk);
    #1;

    // Round-robin wrap
    rr_en = 1'b1;
    for (int i = 1; i <= 6; i++) send(8'(i), 2'd0);
    check("rr_end_ptr", rr_ptr, 2);
    out_ready = 4'b1011;
    for (int i = 7; i <= 10; i++) send(8'(i), 2'd3);
    fork
      send(8'h0B, 2'd0);
      begin
        repeat (3) @(negedge clk);
        check("rr_stall_ptr", rr_ptr, 2);
        check("rr_stall_ready", in_ready, 0);
        @(posedge clk);
        #1 out_ready = 4'b1111;
      end
    join
    check("rr_after_stall", rr_ptr, 3);
    repeat (2) @(posedge clk);
    #1;

    // Simultaneous drain + load on slot 3
    rr_en     = 1'b0;
    out_ready = 4'b0111;
    send(8'h5A, 2'd3);
    check("dl_full", out3_data, 8'h5A);
    out_ready = 4'b1111;
    send(8'hC3, 2'd3);
    check("dl_valid", out_valid[3], 1);
    check("dl_data", out3_data, 8'hC3);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-stream with every slot full
    out_ready = 4'b0000;
    for (int i = 0; i < 4; i++) send(8'h40 + 8'(i), 2'(i));
    check("mid_full", out_valid, 4'hF);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ptr", rr_ptr, 0);
    out_ready = 4'b1111;
    repeat (4) @(posedge clk);
    #1;
    check("mid_no_emit", out_valid, 0);

    for (int n = 0; n < 4; n++) check($sformatf("sb%0d_empty", n), sb[n].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux1to4_stream.md
# demux1to4_stream

Registered 1-to-4 stream demultiplexer with per-output valid/ready handshakes. It accepts one input beat per cycle and steers it to one of four output ports, selected either by an explicit select or by round-robin rotation. Each output has a one-entry holding register, so all outputs are registered and back-pressure on one output stalls only beats aimed at that output. It sits on the opposite side of a 4:1 mux and fans a shared datapath back out to four consumers.

## Interface
- WIDTH, 1, data width of the input and each output
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- rr_en  input  1  1: round-robin target; 0: target = in_sel
- in_valid  input  1  input beat present
- in_ready  output  1  input beat accepted this cycle when in_valid & in_ready
- in_sel  input  2  target output (00→out0 … 11→out3), used when rr_en=0
- in_data  input  WIDTH  input payload
- out_valid  output  4  per-output holding register full
- out_ready  input  4  per-output consumer ready
- out0_data, out1_data, out2_data, out3_data  output  WIDTH each  payload of holding register n
- rr_ptr  output  2  current round-robin target (observability)

## Operation
- Target t = rr_en ? rr_ptr : in_sel.
- Slot n is free when out_valid[n]=0 or out_ready[n]=1 (drained this cycle).
- in_ready = slot t free. It is combinational from rr_en, in_sel, rr_ptr, out_valid[t] and out_ready[t]. It is independent of in_valid.
- Accept (in_valid & in_ready):
  - outN_data[t] <= in_data
  - out_valid[t] <= 1
- Drain slot n (out_valid[n] & out_ready[n]) with no accept into n: out_valid[n] <= 0. The data register holds its last value.
- Simultaneous drain and accept on the same slot: out_valid stays 1 and the data is replaced. Full throughput is 1 beat/cycle per slot.
- Non-target slots drain independently in the same cycle.
- Round-robin:
  - rr_ptr advances 0→1→2→3→0 (wraps) only on an accepted beat while rr_en=1.
  - rr_ptr holds otherwise, including while stalled on a full target.
  - rr_ptr does not reset when rr_en toggles.
- Toggling rr_en or changing in_sel while in_valid=1 and in_ready=0 is legal. The target is re-evaluated each cycle, and no beat is lost or duplicated.
- Data path is pure copy. There is no width conversion or arithmetic other than the 2-bit wrapping pointer.

## Timing
- Reset (rst_n=0 sampled at a clk edge):
  - out_valid=4'b0000, all outN_data='0, rr_ptr=2'b00.
  - in_ready reflects the empty slots immediately after reset (=1).
- Reset mid-operation discards held beats. No out_valid may stay high after the reset edge.
- Latency: a beat accepted at edge k appears with out_valid[t]=1 at the output after edge k. The minimum is 1 cycle, and there is no combinational path from in_data to any output.
- The in_ready → in_valid combinational loop is forbidden. Upstream must not derive in_valid from in_ready.
- Outputs obey AXI-style rules: once out_valid[n]=1, outN_data stays stable until the slot drains.

## Structure
- Package demux_pkg:
  - NUM_PORTS=4
  - typedef logic [1:0] port_sel_t for in_sel and rr_ptr
  - helper function next_ptr(port_sel_t) returning the wrapped increment
- Sub-module demux_slot #(WIDTH): one holding register, taking load, drain, in_data and producing valid, data and free. It is instantiated four times from a generate loop.
- The top level holds target selection, the in_ready mux, load decode and the rr_ptr register.

## Test plan
- Reset:
  - Assert rst_n=0 for 2 cycles with garbage on inputs → out_valid=0000, rr_ptr=0, all data=0, in_ready=1.
- Explicit steering:
  - rr_en=0, WIDTH=8, out_ready=1111.
  - Send 0xA0..0xA3 with in_sel=0,1,2,3 on consecutive cycles.
  - Expected: each appears on outN_data one cycle later with a single-cycle out_valid pulse, and in_ready stays 1.
- Back-pressure isolation:
  - out_ready=1110, send 0x11 to port 0, then 0x22 to port 0, then 0x33 to port 1.
  - Expected: out0 holds 0x11 and in_ready=0 on the second beat until out_ready[0]=1.
  - Then 0x22 is accepted, followed by 0x33 to out1 with no loss or reordering per port.
- Round-robin wrap:
  - rr_en=1, all ready, send 6 beats 0x01..0x06.
  - Expected: they land on ports 0,1,2,3,0,1 and rr_ptr ends at 2.
  - A stalled beat (out_ready[2]=0 with slot 2 full) does not advance rr_ptr.
- Simultaneous drain+load:
  - Slot 3 full with 0x5A, out_ready[3]=1, accept 0xC3 to port 3 in the same cycle.
  - Expected: out_valid[3] stays 1 and out3_data=0xC3 next cycle.
- Reset mid-stream:
  - All slots full and out_ready=0000, pulse rst_n=0 for one cycle.
  - Expected: out_valid=0000 and rr_ptr=0 next cycle, with no held beat emitted afterward.
